fft_stream_out: RTL and testbench
=================================

Name: fft_stream_out

Overview:
- Output-side unloader for the 16-point FFT core.
- Captures one full frame of parallel complex results (real bus and imaginary bus, bin k at bits [W*k+W-1 : W*k]) in a single load handshake.
- Streams the frame out one bin per cycle on a valid/ready interface toward downstream consumers (DMA/UART bridge).
- Inverse of the core's parallel-bus interface: parallel-in, serial-out, with backpressure.

Parameters:
- NPT, 16, number of FFT points; must be a power of two, 2..64.
- W, 32, bit width of each real/imag word (Q16.16 two's complement, passed through unmodified).
- IW, 4, index width, equal to log2(NPT).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- load_valid  input  1  parallel frame present on re_bus/im_bus.
- load_ready  output  1  block can accept a frame this cycle.
- re_bus  input  W*NPT  real parts, bin k at [W*k+W-1 : W*k].
- im_bus  input  W*NPT  imaginary parts, same packing.
- out_valid  output  1  out_re/out_im/out_idx/out_last hold a valid beat.
- out_ready  input  1  downstream accepts the beat.
- out_re  output  W  real part of current bin.
- out_im  output  W  imaginary part of current bin.
- out_idx  output  IW  bin number of current beat.
- out_last  output  1  high on the final beat of a frame.
- frame_cnt  output  16  count of fully streamed frames, wraps at 0xFFFF to 0.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, load_ready=1, out_valid=0, beat counter=0, frame_cnt=0, out_idx=0, out_last=0. Buffer contents are don't-care; out_re and out_im are 0.
- Load handshake: a frame is captured when load_valid && load_ready at a rising edge. Both buses are copied entirely into an internal NPT×2W register buffer in that edge.
- IDLE state:
  - load_ready=1, out_valid=0.
  - On a load: go to STREAM, counter=0, out_valid=1 on the next cycle.
  - Latency from load edge to first valid beat is 1 cycle.
- STREAM state:
  - out_valid=1.
  - out_re/out_im = buffer[slot(counter)], out_idx = slot(counter), out_last = (counter==NPT-1).
  - The beat transfers when out_valid && out_ready.
  - On transfer with counter<NPT-1: counter+1.
  - With out_ready=0: all out_* held stable, with no change of counter or buffer.
- Frame end, on transfer of the last beat:
  - frame_cnt+1.
  - load_ready=1 combinationally in that cycle only (load_ready = IDLE || (out_valid && out_ready && out_last)).
  - If load_valid is also high: the new frame is captured in the same edge, counter=0, remain in STREAM. This gives back-to-back frames with no bubble.
  - Otherwise: return to IDLE.
- Outside the last-beat cycle in STREAM, load_ready=0. load_valid is ignored and the upstream must hold its bus.
- Reset mid-stream: immediate abort. The frame is discarded, all outputs take their reset values, and frame_cnt is cleared.
- slot(counter) is counter in natural order. See the optional feature for the alternative.
- No arithmetic on data. Words are passed bit-exact.

Optional Feature:
- Macro FFT_STREAM_BITREV_EN.
- Defined: slot(counter) = bit-reverse of counter over IW bits. The frame streams in bit-reversed bin order, and out_idx reports the bit-reversed index actually emitted. This supports feeding a core whose output buses are in bit-reversed order, or a consumer expecting that order.
- Undefined: natural order, out_idx = counter. The bit-reversal logic is not synthesized.

Test Plan:
- Reset/idle: hold rst_n=0 5 cycles, release -> load_ready=1, out_valid=0, frame_cnt=0.
- Single frame, natural order:
  - Stimulus: re bin0=0x0011_0000, bin1=0x1000_0000, rest 0; im all 0; out_ready=1.
  - Required: 16 consecutive beats starting 1 cycle after load; beat0 re=0x0011_0000, beat1 re=0x1000_0000, others 0; out_idx 0..15; out_last only on idx 15; frame_cnt=1.
- Backpressure:
  - Stimulus: re bin k = k<<16; toggle out_ready 1,0,0,1 pattern.
  - Required: out_* stable whenever out_ready=0; all 16 values delivered once, in order, none dropped or duplicated.
- Back-to-back frames:
  - Stimulus: assert load_valid with frame B (bin k = 0x100+k) during frame A's last beat.
  - Required: load_ready=1 only that cycle; B's beat0 follows A's last beat with no idle cycle; frame_cnt=2.
- Reset mid-stream: drop rst_n after beat 7 -> out_valid=0 asynchronously, frame_cnt=0, next load streams from idx 0.
- Bit-reversed order, FFT_STREAM_BITREV_EN defined: re bin k=k -> out_idx sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15 with out_re equal to out_idx each beat.

Source files
------------

// File: rtl/fft_stream_out.sv
// fft_stream_out: captures one parallel FFT frame, streams it one bin per beat.
// Optional bit-reversed bin order when FFT_STREAM_BITREV_EN is defined.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   load_valid/load_ready      parallel frame handshake (re_bus, im_bus)
//   re_bus, im_bus             NPT words of W bits, bin k at [W*k +: W]
//   out_valid/out_ready        serial beat handshake
//   out_re, out_im             current bin data, bit-exact passthrough
//   out_idx, out_last          bin number, last-beat flag
//   frame_cnt                  fully streamed frames, wraps at 16 bits
module fft_stream_out #(
  parameter int NPT = 16,
  parameter int W   = 32,
  parameter int IW  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic [W*NPT-1:0] re_bus,
  input  logic [W*NPT-1:0] im_bus,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_re,
  output logic [W-1:0]    out_im,
  output logic [IW-1:0]   out_idx,
  output logic            out_last,
  output logic [15:0]     frame_cnt
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;

  logic [0:0]    state;
  logic [IW-1:0] cnt;
  logic [IW-1:0] slot;
  logic [W-1:0]  re_buf [NPT];
  logic [W-1:0]  im_buf [NPT];
  logic          xfer;
  logic          last;
  logic          load;

`ifdef FFT_STREAM_BITREV_EN
  always_comb begin
    slot = '0;
    for (int i = 0; i < IW; i++)
      slot[i] = cnt[IW-1-i];
  end
`else
  assign slot = cnt;
`endif

  assign last       = (cnt == IW'(NPT-1));
  assign out_valid  = (state == STREAM);
  assign xfer       = out_valid && out_ready;
  // Ready opens during the final beat so a new frame can follow with no bubble.
  assign load_ready = (state == IDLE) || (xfer && last);
  assign load       = load_valid && load_ready;
  assign out_idx    = slot;
  assign out_last   = out_valid && last;
  // Buffer is unreset; gate data so idle/reset outputs read as zero.
  assign out_re     = out_valid ? re_buf[slot] : '0;
  assign out_im     = out_valid ? im_buf[slot] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      frame_cnt <= '0;
    end else begin
      if (xfer && last)
        frame_cnt <= frame_cnt + 16'd1;
      if (load) begin
        state <= STREAM;
        cnt   <= '0;
      end else if (xfer) begin
        if (last) begin
          state <= IDLE;
          cnt   <= '0;
        end else begin
          cnt <= cnt + IW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < NPT; k++) begin
        re_buf[k] <= re_bus[W*k +: W];
        im_buf[k] <= im_bus[W*k +: W];
      end
    end
  end

endmodule

// File: tb/tb_fft_stream_out.sv
// tb_fft_stream_out: directed bench for fft_stream_out.
// Drives and samples on the falling edge.
module tb_fft_stream_out;

  localparam int NPT = 16;
  localparam int W   = 32;
  localparam int IW  = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             load_valid;
  logic             load_ready;
  logic [W*NPT-1:0] re_bus;
  logic [W*NPT-1:0] im_bus;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_re;
  logic [W-1:0]     out_im;
  logic [IW-1:0]    out_idx;
  logic             out_last;
  logic [15:0]      frame_cnt;

  int errs = 0;
  int checks = 0;

  fft_stream_out #(.NPT(NPT), .W(W), .IW(IW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .re_bus     (re_bus),
    .im_bus     (im_bus),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_re     (out_re),
    .out_im     (out_im),
    .out_idx    (out_idx),
    .out_last   (out_last),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_re(input int mode, input int k);
    case (mode)
      0: exp_re = (k == 0) ? 32'h0011_0000 :
                  (k == 1) ? 32'h1000_0000 : 32'h0;
      1: exp_re = W'(k) << 16;
      2: exp_re = 32'h100 + W'(k);
      default: exp_re = W'(k);
    endcase
  endfunction

  function automatic logic [W-1:0] exp_im(input int mode, input int k);
    exp_im = (mode == 0) ? 32'h0 : (exp_re(mode, k) ^ 32'hA5A5_5A5A);
  endfunction

  function automatic int slot_of(input int b);
`ifdef FFT_STREAM_BITREV_EN
    slot_of = 0;
    for (int i = 0; i < IW; i++)
      if (b[i]) slot_of |= 1 << (IW-1-i);
`else
    slot_of = b;
`endif
  endfunction

  task automatic set_bus(input int mode);
    for (int k = 0; k < NPT; k++) begin
      re_bus[W*k +: W] = exp_re(mode, k);
      im_bus[W*k +: W] = exp_im(mode, k);
    end
  endtask

  // Called on a falling edge with the block idle.
  task automatic load_frame(input int mode);
    set_bus(mode);
    load_valid = 1'b1;
    chk("load_ready_idle", 64'(load_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    load_valid = 1'b0;
    chk("first_beat_latency", 64'(out_valid), 64'd1);
  endtask

  // Accepts nbeats beats of frame 'mode'; bp applies a 1,0,0,1 ready pattern;
  // next >= 0 offers that frame during the last beat.
  task automatic collect(input int mode, input bit bp, input int next,
                         input int nbeats);
    int beats = 0;
    int cyc = 0;
    int s;
    bit stall = 1'b0;
    logic [W-1:0] p_re, p_im;
    logic [IW-1:0] p_idx;
    logic p_last;
    while (beats < nbeats && cyc < 300) begin
      out_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (!bp)
        chk("no_gap", 64'(out_valid), 64'd1);
      if (stall) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_re", 64'(out_re), 64'(p_re));
        chk("hold_im", 64'(out_im), 64'(p_im));
        chk("hold_idx", 64'(out_idx), 64'(p_idx));
        chk("hold_last", 64'(out_last), 64'(p_last));
      end
      if (out_valid && out_ready) begin
        s = slot_of(beats);
        chk("idx", 64'(out_idx), 64'(s));
        chk("re", 64'(out_re), 64'(exp_re(mode, s)));
        chk("im", 64'(out_im), 64'(exp_im(mode, s)));
        chk("last", 64'(out_last), 64'(beats == NPT-1));
        if (beats == 5)
          chk("load_ready_mid", 64'(load_ready), 64'd0);
        if (beats == NPT-1 && next >= 0) begin
          set_bus(next);
          load_valid = 1'b1;
          chk("load_ready_last", 64'(load_ready), 64'd1);
        end
        beats++;
      end
      stall = out_valid && !out_ready;
      p_re = out_re;
      p_im = out_im;
      p_idx = out_idx;
      p_last = out_last;
      cyc++;
      @(posedge clk);
      @(negedge clk);
      load_valid = 1'b0;
    end
    if (beats < nbeats)
      chk("beat_timeout", 64'(beats), 64'(nbeats));
    out_ready = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    load_valid = 1'b0;
    out_ready = 1'b1;
    re_bus = '0;
    im_bus = '0;
    repeat (5) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_out_idx", 64'(out_idx), 64'd0);
    chk("rst_out_re", 64'(out_re), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_load_ready", 64'(load_ready), 64'd1);
    chk("idle_out_valid", 64'(out_valid), 64'd0);
    chk("idle_frame_cnt", 64'(frame_cnt), 64'd0);

    // single frame, full throughput
    load_frame(0);
    collect(0, 1'b0, -1, NPT);
    chk("single_done_valid", 64'(out_valid), 64'd0);
    chk("single_frame_cnt", 64'(frame_cnt), 64'd1);
    chk("single_load_ready", 64'(load_ready), 64'd1);

    // backpressure
    load_frame(1);
    collect(1, 1'b1, -1, NPT);
    chk("bp_done_valid", 64'(out_valid), 64'd0);
    chk("bp_frame_cnt", 64'(frame_cnt), 64'd2);

    // back-to-back: A = bin k is k, B = 0x100+k
    load_frame(3);
    collect(3, 1'b0, 2, NPT);
    chk("b2b_no_bubble", 64'(out_valid), 64'd1);
    chk("b2b_first_idx", 64'(out_idx), 64'd0);
    chk("b2b_cnt_a", 64'(frame_cnt), 64'd3);
    chk("b2b_ready_low", 64'(load_ready), 64'd0);
    collect(2, 1'b0, -1, NPT);
    chk("b2b_done_valid", 64'(out_valid), 64'd0);
    chk("b2b_frame_cnt", 64'(frame_cnt), 64'd4);

    // reset mid-stream after beat 7
    load_frame(1);
    collect(1, 1'b0, -1, 8);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 64'(out_valid), 64'd0);
    chk("abort_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("abort_load_ready", 64'(load_ready), 64'd1);
    chk("abort_idx", 64'(out_idx), 64'd0);
    chk("abort_re", 64'(out_re), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load_frame(3);
    collect(3, 1'b0, -1, NPT);
    chk("post_rst_frame_cnt", 64'(frame_cnt), 64'd1);
    chk("post_rst_valid", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
